ula_arbiter: RTL and testbench



---
 rtl/ula_arbiter_if.sv | 59 +++++
 rtl/ula_arbiter.sv | 95 +++++++++
 tb/tb_ula_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ula_arbiter_if.sv
// Bundle of requester, ULA-side and response signals for ula_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface ula_arbiter_if #(
  parameter int bits = 16
);
  logic            req0_valid;
  logic            req0_ready;
  logic [bits-1:0] req0_a;
  logic [bits-1:0] req0_b;
  logic [7:0]      req0_op;

  logic            req1_valid;
  logic            req1_ready;
  logic [bits-1:0] req1_a;
  logic [bits-1:0] req1_b;
  logic [7:0]      req1_op;

  logic [bits-1:0] ula_a;
  logic [bits-1:0] ula_b;
  logic [7:0]      ula_op;
  logic [bits-1:0] ula_resu;
  logic            ula_o;
  logic            ula_c;
  logic            ula_s;
  logic            ula_z;

  logic            resp_valid;
  logic            resp_ready;
  logic            resp_id;
  logic [bits-1:0] resp_data;
  logic [3:0]      resp_flags;
  logic [3:0]      flags;
  logic            busy;
  logic [15:0]     ops_done;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output ula_a, ula_b, ula_op,
    input  ula_resu, ula_o, ula_c, ula_s, ula_z,
    output resp_valid, resp_id, resp_data, resp_flags,
    input  resp_ready,
    output flags, busy, ops_done
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  ula_a, ula_b, ula_op,
    output ula_resu, ula_o, ula_c, ula_s, ula_z,
    input  resp_valid, resp_id, resp_data, resp_flags,
    output resp_ready,
    input  flags, busy, ops_done
  );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin sharing of one combinational ULA between two requesters.
// state | meaning: IDLE grant/accept, EXEC ULA settles then capture, RESP hold response until taken
module ula_arbiter #(
  parameter int bits = 16
) (
  input logic         clk,
  input logic         rst,
  ula_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  logic [1:0]      r_state;
  logic            r_last_gnt;
  logic [bits-1:0] r_ula_a;
  logic [bits-1:0] r_ula_b;
  logic [7:0]      r_ula_op;
  logic            r_resp_id;
  logic [bits-1:0] r_resp_data;
  logic [3:0]      r_resp_flags;
  logic [3:0]      r_flags;
  logic [15:0]     r_ops_done;

  logic            w_idle;
  logic            w_gnt;
  logic            w_rdy0;
  logic            w_rdy1;
  logic            w_accept;
  logic [3:0]      w_next_flags;

  // On a tie the requester not granted last wins; r_last_gnt=1 after reset favours req0.
  assign w_idle   = (r_state == IDLE);
  assign w_gnt    = (bus.req0_valid && bus.req1_valid) ? ~r_last_gnt : bus.req1_valid;
  assign w_rdy0   = w_idle && bus.req0_valid && !w_gnt;
  assign w_rdy1   = w_idle && bus.req1_valid && w_gnt;
  assign w_accept = w_rdy0 || w_rdy1;

  // Constant formats (op[7:6] = 01/11) leave the architectural flags untouched.
  assign w_next_flags = r_ula_op[6] ? r_flags : {bus.ula_o, bus.ula_c, bus.ula_s, bus.ula_z};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_gnt   <= 1'b1;
      r_ula_a      <= '0;
      r_ula_b      <= '0;
      r_ula_op     <= '0;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
      r_resp_flags <= '0;
      r_flags      <= '0;
      r_ops_done   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ula_a    <= w_gnt ? bus.req1_a  : bus.req0_a;
            r_ula_b    <= w_gnt ? bus.req1_b  : bus.req0_b;
            r_ula_op   <= w_gnt ? bus.req1_op : bus.req0_op;
            r_resp_id  <= w_gnt;
            r_last_gnt <= w_gnt;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          r_resp_data  <= bus.ula_resu;
          r_flags      <= w_next_flags;
          r_resp_flags <= w_next_flags;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_ops_done <= r_ops_done + 16'd1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.ula_a      = r_ula_a;
  assign bus.ula_b      = r_ula_b;
  assign bus.ula_op     = r_ula_op;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_flags = r_resp_flags;
  assign bus.flags      = r_flags;
  assign bus.busy       = !w_idle;
  assign bus.ops_done   = r_ops_done;
endmodule

// File: tb/tb_ula_arbiter.sv
// Bench for ula_arbiter: adder ULA stub, directed scenarios, then randomized traffic
// against a transaction-level model of grants, flags and the completion count.
module tb_ula_arbiter;
  localparam int bits = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ula_arbiter_if #(.bits(bits)) bus();

  ula_arbiter #(.bits(bits)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [16:0] w_sum;
  assign w_sum        = {1'b0, bus.ula_a} + {1'b0, bus.ula_b};
  assign bus.ula_resu = w_sum[15:0];
  assign bus.ula_c    = w_sum[16];
  assign bus.ula_s    = w_sum[15];
  assign bus.ula_z    = (w_sum[15:0] == 16'h0000);
  assign bus.ula_o    = (bus.ula_a[15] == bus.ula_b[15]) && (w_sum[15] != bus.ula_a[15]);

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        m_last;
  logic [3:0]  m_flags;
  logic [15:0] m_ops;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Flags straight from integer arithmetic: {O,C,S,Z}.
  function automatic logic [3:0] f_flags(input logic [15:0] a, input logic [15:0] b);
    int u;
    int sg;
    logic [3:0] f;
    u    = int'(a) + int'(b);
    sg   = int'($signed(a)) + int'($signed(b));
    f[3] = (sg > 32767) || (sg < -32768);
    f[2] = (u > 65535);
    f[1] = ((u % 65536) >= 32768);
    f[0] = ((u % 65536) == 0);
    return f;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    chk({tag, "_ula_ab"}, {bus.ula_a, bus.ula_b}, 32'd0);
    chk({tag, "_ula_op"}, 32'(bus.ula_op), 32'd0);
    chk({tag, "_vld_id_busy"}, 32'({bus.resp_valid, bus.resp_id, bus.busy}), 32'd0);
    chk({tag, "_resp_data"}, 32'(bus.resp_data), 32'd0);
    chk({tag, "_flags"}, 32'({bus.resp_flags, bus.flags}), 32'd0);
    chk({tag, "_ops_done"}, 32'(bus.ops_done), 32'd0);
  endtask

  task automatic model_reset();
    m_last  = 1'b1;
    m_flags = 4'b0000;
    m_ops   = 16'd0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_hold");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_zero("rst_release");
    @(posedge clk); #1;
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic do_op(input logic v0, input logic v1,
                       input logic [15:0] a0, input logic [15:0] b0, input logic [7:0] op0,
                       input logic [15:0] a1, input logic [15:0] b1, input logic [7:0] op1,
                       input int delay, input logic keep_other);
    logic        g;
    logic [15:0] ea, eb, ed;
    logic [7:0]  eop;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
    g = (v0 && v1) ? ~m_last : v1;
    @(negedge clk);
    chk("grant", 32'({bus.req1_ready, bus.req0_ready}), g ? 32'd2 : 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    m_last = g;
    ea  = g ? a1 : a0;
    eb  = g ? b1 : b0;
    eop = g ? op1 : op0;
    ed  = 16'((int'(ea) + int'(eb)) % 65536);
    if (eop[7:6] == 2'b00 || eop[7:6] == 2'b10) m_flags = f_flags(ea, eb);
    // Winner drops valid and scrambles its bus; the capture must already be done.
    if (g) begin
      bus.req1_valid = 1'b0; bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom);
      bus.req1_op = 8'($urandom);
    end else begin
      bus.req0_valid = 1'b0; bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom);
      bus.req0_op = 8'($urandom);
    end
    if (!keep_other) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    bus.resp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("exec_state", 32'({bus.busy, bus.resp_valid, bus.req1_ready, bus.req0_ready}), 32'h8);
    chk("ula_ab", {bus.ula_a, bus.ula_b}, {ea, eb});
    chk("ula_op", 32'(bus.ula_op), 32'(eop));
    @(posedge clk); #1;
    bus.resp_ready = (delay == 0);
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      chk("resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("resp_id", 32'(bus.resp_id), 32'(g));
      chk("resp_data", 32'(bus.resp_data), 32'(ed));
      chk("resp_flags", 32'({bus.resp_flags, bus.flags}), 32'({m_flags, m_flags}));
      chk("resp_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      chk("ops_hold", 32'(bus.ops_done), 32'(m_ops));
      @(posedge clk); #1;
      bus.resp_ready = (i + 1 == delay);
    end
    m_ops = m_ops + 16'd1;
    bus.resp_ready = 1'b0;
    chk("ops_done", 32'(bus.ops_done), 32'(m_ops));
    chk("resp_done", 32'({bus.resp_valid, bus.busy}), 32'd0);
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.resp_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    apply_reset();

    do_op(1, 0, 16'h0003, 16'h0004, 8'h00, 16'h0000, 16'h0000, 8'h00, 0, 0);
    chk("single_flags", 32'(bus.flags), 32'h0);

    apply_reset();
    for (int i = 0; i < 4; i++)
      do_op(1, 1, 16'(100 + i), 16'(i), 8'h00, 16'(200 + i), 16'(i), 8'h80, 0, 1);

    do_op(1, 0, 16'h7FFF, 16'h0001, 8'h00, 16'h0000, 16'h0000, 8'h00, 0, 0);
    chk("ovf_flags", 32'(bus.flags), 32'hA);
    do_op(1, 0, 16'hFFFF, 16'h0001, 8'h40, 16'h0000, 16'h0000, 8'h00, 0, 0);
    chk("const_hold", 32'(bus.flags), 32'hA);

    do_op(0, 1, 16'h0000, 16'h0000, 8'h00, 16'h1234, 16'h4321, 8'h80, 5, 0);

    // Reset while the ULA stage is active: the operation must vanish.
    bus.req0_valid = 1'b1; bus.req0_a = 16'h00AA; bus.req0_b = 16'h0055; bus.req0_op = 8'h00;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    check_zero("rst_exec");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_resp_after_rst", 32'({bus.resp_valid, bus.busy, bus.ops_done}), 32'd0);
    end
    @(posedge clk); #1;
    do_op(0, 1, 16'h0000, 16'h0000, 8'h00, 16'h0010, 16'h0020, 8'h00, 1, 0);

    for (int n = 0; n < 60; n++) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      do_op(v0, v1, 16'($urandom), 16'($urandom), 8'($urandom),
            16'($urandom), 16'($urandom), 8'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
